bcd_countdown_ctrl: RTL and testbench

- Sequencer for an external 8-bit, 2-digit BCD decade down counter (ports D, LD, EN, CS, Q; range 00–99; wraps 00→99 on enable).
- Turns start, pause and abort commands into registered LD/EN/CS strobes.
- Paces EN with a prescaler.
- Stops the counter at 00, or reloads it (auto-reload), so the counter never wraps.
- Sits between a host or register interface and the counter macro.

---
 rtl/bcd_countdown_pkg.sv | 19 +
 rtl/bcd_tick_div.sv | 38 +++
 rtl/bcd_countdown_ctrl.sv | 130 +++++++++++++
 tb/tb_bcd_countdown_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_countdown_pkg.sv
// Shared types and helpers for the BCD countdown sequencer.
// States, the BCD zero constant and a two-digit BCD validity check.
package bcd_countdown_pkg;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PAUSED
    } state_e;

    localparam logic [7:0] BCD_ZERO = 8'h00;

    function automatic logic is_bcd8(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_tick_div.sv
// Count-tick prescaler: wraps every PRESCALE cycles, clearable and freezable.
// tick_o is high during the last cycle of each period.
module bcd_tick_div #(
    parameter int PRESCALE = 10,
    parameter int PW       = $clog2(PRESCALE)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic hold_i,
    output logic tick_o
);

    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (!hold_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bcd_countdown_ctrl.sv
// Sequencer driving an external 2-digit BCD down counter via LD/EN/CS.
// Stops or reloads at 00 so the counter never wraps to 99.
module bcd_countdown_ctrl
    import bcd_countdown_pkg::*;
#(
    parameter  int PRESCALE = 10,
    localparam int PW       = $clog2(PRESCALE)
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       START,
    input  logic       PAUSE,
    input  logic       ABORT,
    input  logic       AUTO_RELOAD,
    input  logic [7:0] PRESET,
    input  logic [7:0] CNT_Q,
    output logic [7:0] CNT_D,
    output logic       CNT_LD,
    output logic       CNT_EN,
    output logic       CNT_CS,
    output logic       BUSY,
    output logic       PAUSED,
    output logic       DONE,
    output logic       ERR
);

    state_e     state_q, state_d;
    logic [7:0] preset_q, preset_d;
    logic       ld_q, ld_d, en_q, en_d, cs_q, cs_d;
    logic       busy_q, busy_d, paused_q, paused_d;
    logic       done_q, done_d, err_q, err_d;

    logic tick, div_clr, div_hold;
    logic in_run, abort_hit, start_hit, start_ok;
    logic stepping, tick_evt, q_zero;

    assign in_run    = (state_q == S_RUN) || (state_q == S_PAUSED);
    assign abort_hit = ABORT && (state_q != S_INIT);
    assign start_hit = START && !abort_hit &&
                       (state_q inside {S_IDLE, S_RUN, S_PAUSED});
    assign start_ok  = start_hit && is_bcd8(PRESET);
    // A PAUSED cycle with PAUSE low already counts, so a pause costs exactly its length
    assign stepping  = in_run && !abort_hit && !start_hit && !PAUSE;
    assign tick_evt  = stepping && tick;
    assign q_zero    = (CNT_Q == BCD_ZERO);

    assign div_clr  = !in_run || abort_hit || start_ok;
    assign div_hold = PAUSE || start_hit;

    bcd_tick_div #(
        .PRESCALE (PRESCALE),
        .PW       (PW)
    ) u_div (
        .clk_i  (CLK),
        .rst_ni (RSTN),
        .clr_i  (div_clr),
        .hold_i (div_hold),
        .tick_o (tick)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= S_INIT;
            preset_q <= BCD_ZERO;
            ld_q     <= 1'b0;
            en_q     <= 1'b0;
            cs_q     <= 1'b0;
            busy_q   <= 1'b0;
            paused_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            preset_q <= preset_d;
            ld_q     <= ld_d;
            en_q     <= en_d;
            cs_q     <= cs_d;
            busy_q   <= busy_d;
            paused_q <= paused_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_INIT) begin
            state_d = S_IDLE;
        end else if (abort_hit) begin
            state_d = S_IDLE;
        end else if (start_ok) begin
            state_d = S_LOAD;
        end else if (!start_hit) begin
            case (state_q)
                S_LOAD: state_d = S_RUN;
                S_RUN, S_PAUSED: begin
                    if (PAUSE) begin
                        state_d = S_PAUSED;
                    end else if (tick_evt && q_zero && !AUTO_RELOAD) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        cs_d     = (state_q == S_INIT) || abort_hit;
        ld_d     = start_ok || (tick_evt && q_zero && AUTO_RELOAD);
        en_d     = tick_evt && !q_zero;
        done_d   = tick_evt && q_zero;
        err_d    = start_hit && !start_ok;
        busy_d   = state_d inside {S_LOAD, S_RUN, S_PAUSED};
        paused_d = (state_d == S_PAUSED);
        preset_d = start_ok ? PRESET : preset_q;
    end

    assign CNT_D  = preset_q;
    assign CNT_LD = ld_q;
    assign CNT_EN = en_q;
    assign CNT_CS = cs_q;
    assign BUSY   = busy_q;
    assign PAUSED = paused_q;
    assign DONE   = done_q;
    assign ERR    = err_q;

endmodule

// File: tb/tb_bcd_countdown_ctrl.sv
// Directed bench for bcd_countdown_ctrl with a behavioural BCD down counter.
// PRESCALE=4; cycle indices count negedges after the START drive.
module tb_bcd_countdown_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start, pause, abort, auto_reload;
    logic [7:0] preset;
    logic [7:0] cq = 8'h55;
    logic [7:0] cnt_d;
    logic       cnt_ld, cnt_en, cnt_cs, busy, paused, done, err;
    logic [14:0] outs;

    int total = 0;
    int bad   = 0;
    int cyc, d1, d2, en_n, ld_n, dl_n, ep_n;
    logic [31:0] trace;
    logic [7:0]  lastq;

    always #5 clk = ~clk;

    bcd_countdown_ctrl #(.PRESCALE(4)) dut (
        .CLK         (clk),
        .RSTN        (rstn),
        .START       (start),
        .PAUSE       (pause),
        .ABORT       (abort),
        .AUTO_RELOAD (auto_reload),
        .PRESET      (preset),
        .CNT_Q       (cq),
        .CNT_D       (cnt_d),
        .CNT_LD      (cnt_ld),
        .CNT_EN      (cnt_en),
        .CNT_CS      (cnt_cs),
        .BUSY        (busy),
        .PAUSED      (paused),
        .DONE        (done),
        .ERR         (err)
    );

    assign outs = {cnt_d, cnt_ld, cnt_en, cnt_cs, busy, paused, done, err};

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v == 8'h00)
            return 8'h99;
        else if (v[3:0] == 4'h0)
            return {v[7:4] - 4'd1, 4'h9};
        else
            return v - 8'd1;
    endfunction

    // External counter: CS > LD > EN, wraps 00 -> 99 when enabled
    always @(posedge clk) begin
        if (cnt_cs)
            cq <= 8'h00;
        else if (cnt_ld)
            cq <= cnt_d;
        else if (cnt_en)
            cq <= bcd_dec(cq);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        cyc   = 0;
        d1    = 0;
        d2    = 0;
        en_n  = 0;
        ld_n  = 0;
        dl_n  = 0;
        ep_n  = 0;
        trace = '0;
        lastq = cq;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (done) begin
            if (d1 == 0)
                d1 = cyc;
            else if (d2 == 0)
                d2 = cyc;
        end
        if (cnt_en) en_n++;
        if (cnt_ld) ld_n++;
        if (done && cnt_ld) dl_n++;
        if (paused && cnt_en) ep_n++;
        if (cq !== lastq) begin
            trace = {trace[23:0], cq};
            lastq = cq;
        end
        chk("strobe_excl", 32'($onehot0({cnt_ld, cnt_en, cnt_cs})), 32'd1);
    endtask

    task automatic pulse_start(input logic [7:0] p);
        clear_stats();
        preset = p;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    initial begin
        rstn        = 1'b0;
        start       = 1'b0;
        pause       = 1'b0;
        abort       = 1'b0;
        auto_reload = 1'b0;
        preset      = 8'h00;
        clear_stats();

        // Reset and INIT clear
        repeat (2) step();
        chk("reset_outs", 32'(outs), 32'h0);
        rstn = 1'b1;
        step();
        chk("init_cs", 32'(cnt_cs), 32'd1);
        chk("init_busy", 32'(busy), 32'd0);
        step();
        chk("init_cs_once", 32'(outs), 32'h0);
        chk("init_cnt_clr", 32'(cq), 32'h00);

        // 03, no reload: DONE at (3+1)*4+2 = 18
        pulse_start(8'h03);
        chk("t1_ld", 32'(cnt_ld), 32'd1);
        chk("t1_d", 32'(cnt_d), 32'h03);
        chk("t1_busy", 32'(busy), 32'd1);
        repeat (23) step();
        chk("t1_done_at", 32'(d1), 32'd18);
        chk("t1_done_once", 32'(d2), 32'd0);
        chk("t1_en_n", 32'(en_n), 32'd3);
        chk("t1_ld_n", 32'(ld_n), 32'd1);
        chk("t1_qseq", trace, 32'h03020100);
        chk("t1_q_hold", 32'(cq), 32'h00);
        chk("t1_idle", 32'(busy), 32'd0);

        // 10 with auto reload: DONE at 46 and 46+11*4 = 90
        auto_reload = 1'b1;
        pulse_start(8'h10);
        repeat (95) step();
        chk("t2_done1", 32'(d1), 32'd46);
        chk("t2_done2", 32'(d2), 32'd90);
        chk("t2_en_n", 32'(en_n), 32'd21);
        chk("t2_ld_n", 32'(ld_n), 32'd3);
        chk("t2_done_ld", 32'(dl_n), 32'd2);
        chk("t2_qtail", trace, 32'h01001009);
        chk("t2_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        auto_reload = 1'b0;
        chk("t2_abort_cs", 32'(cnt_cs), 32'd1);
        chk("t2_abort_idle", 32'(busy), 32'd0);
        step();
        chk("t2_abort_q", 32'(cq), 32'h00);

        // Invalid presets rejected, 99 accepted
        pulse_start(8'h1A);
        chk("t3_err_1a", 32'(err), 32'd1);
        chk("t3_no_ld_1a", 32'(cnt_ld), 32'd0);
        chk("t3_idle_1a", 32'(busy), 32'd0);
        step();
        chk("t3_err_pulse", 32'(err), 32'd0);
        pulse_start(8'hA0);
        chk("t3_err_a0", 32'(err), 32'd1);
        chk("t3_no_ld_a0", 32'(cnt_ld), 32'd0);
        chk("t3_latch_kept", 32'(cnt_d), 32'h10);
        step();
        pulse_start(8'h99);
        chk("t3_err_99", 32'(err), 32'd0);
        chk("t3_ld_99", 32'(cnt_ld), 32'd1);
        chk("t3_d_99", 32'(cnt_d), 32'h99);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t3_abort_cs", 32'(cnt_cs), 32'd1);
        step();
        chk("t3_abort_q", 32'(cq), 32'h00);

        // Pause 7 cycles: DONE moves from 18 to 25
        pulse_start(8'h03);
        repeat (5) step();
        pause = 1'b1;
        repeat (7) step();
        chk("t4_paused", 32'(paused), 32'd1);
        chk("t4_busy", 32'(busy), 32'd1);
        pause = 1'b0;
        step();
        chk("t4_resumed", 32'(paused), 32'd0);
        repeat (16) step();
        chk("t4_done_at", 32'(d1), 32'd25);
        chk("t4_en_n", 32'(en_n), 32'd3);
        chk("t4_en_paused", 32'(ep_n), 32'd0);
        chk("t4_q", 32'(cq), 32'h00);

        // ABORT beats START in RUN
        pulse_start(8'h05);
        repeat (3) step();
        abort  = 1'b1;
        start  = 1'b1;
        preset = 8'h07;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("t5_cs", 32'(cnt_cs), 32'd1);
        chk("t5_no_ld", 32'(cnt_ld), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);
        chk("t5_latch", 32'(cnt_d), 32'h05);
        step();
        chk("t5_q", 32'(cq), 32'h00);

        // Restart in RUN at Q=05: DONE at (8+1)*4+2 = 38 after restart
        pulse_start(8'h05);
        repeat (3) step();
        chk("t6_q05", 32'(cq), 32'h05);
        pulse_start(8'h08);
        chk("t6_ld", 32'(cnt_ld), 32'd1);
        chk("t6_d", 32'(cnt_d), 32'h08);
        repeat (39) step();
        chk("t6_done_at", 32'(d1), 32'd38);
        chk("t6_en_n", 32'(en_n), 32'd8);

        // Async reset mid-RUN
        pulse_start(8'h09);
        repeat (9) step();
        chk("t7_busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        chk("t7_async_outs", 32'(outs), 32'h0);
        step();
        rstn = 1'b1;
        step();
        chk("t7_init_cs", 32'(cnt_cs), 32'd1);
        step();
        chk("t7_idle", 32'(outs), 32'h0);
        chk("t7_q", 32'(cq), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
